chan_mod_accum: RTL

// - Multi-channel modular accumulator. Successor to the single-channel WIDTH-parametrised

---
 rtl/chan_mod_accum_pkg.sv | 29 ++
 rtl/chan_mod_accum_if.sv | 20 ++
 rtl/chan_mod_accum_bank.sv | 32 +++
 rtl/chan_mod_accum.sv | 81 ++++++++
 4 files changed

// File: rtl/chan_mod_accum_pkg.sv
// Shared arithmetic helpers and the result-beat record for the modular accumulator.
// Widths here are upper bounds; instances narrow them with casts.
package c_math;

    localparam int MAX_W    = 16;
    localparam int MAX_CH_W = 8;

    typedef struct packed {
        logic [MAX_CH_W-1:0] chan;
        logic [MAX_W-1:0]    data;
        logic                wrap;
    } beat_t;

    // Single conditional subtract: valid because callers only pass x < 2*m.
    function automatic logic [MAX_W-1:0] modulo(input logic [MAX_W:0] x, input logic [MAX_W:0] m);
        logic [MAX_W:0] r;
        r = (x >= m) ? (x - m) : x;
        return MAX_W'(r);
    endfunction

    function automatic logic [MAX_W:0] modulo_add(input logic [MAX_W-1:0] a,
                                                   input logic [MAX_W-1:0] b,
                                                   input logic [MAX_W:0]   m);
        logic [MAX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {(s >= m), modulo(s, m)};
    endfunction

endpackage

// File: rtl/chan_mod_accum_if.sv
// Sample-in / result-out handshake bundle of the modular accumulator.
interface chan_mod_accum_if #(
    parameter int CH_W  = 2,
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [CH_W-1:0]  in_chan;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_chan;
    logic [WIDTH-1:0] out_data;
    logic             out_wrap;

    modport master (output in_valid, in_chan, in_data, out_ready,
                    input  in_ready, out_valid, out_chan, out_data, out_wrap);
    modport slave  (input  in_valid, in_chan, in_data, out_ready,
                    output in_ready, out_valid, out_chan, out_data, out_wrap);
endinterface

// File: rtl/chan_mod_accum_bank.sv
// Per-channel sum registers with one combinational read / registered write port.
// Reads of an out-of-range channel return zero.
module mod_accum_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 4,
    parameter int CH_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [CH_W-1:0]  chan_i,
    output logic [WIDTH-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i
);
    logic [WIDTH-1:0] acc_q [NUM_CH];

    assign rd_data_o = (int'(chan_i) < NUM_CH) ? acc_q[chan_i] : '0;

    // Sum array: async reset, synchronous clear, single-channel update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else if (wr_en_i) begin
            acc_q[chan_i] <= wr_data_i;
        end else begin
            acc_q <= acc_q;
        end
    end
endmodule

// File: rtl/chan_mod_accum.sv
// Multi-channel modular accumulator: handshake, legality checks and the
// one-entry output register around the per-channel sum bank.
module chan_mod_accum
    import c_math::*;
#(
    parameter int NUM_CH  = 4,
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    output logic               err_o,
    chan_mod_accum_if.slave    bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [MAX_W:0] MOD_L = (MAX_W + 1)'(MODULUS);

    if (NUM_CH < 1 || MODULUS < 2 || MODULUS > 2 ** WIDTH || WIDTH > MAX_W || CH_W > MAX_CH_W) begin : g_bad_cfg
        $error("chan_mod_accum: illegal parameter combination");
    end

    logic             accept_s;
    logic             legal_s;
    logic [WIDTH-1:0] rd_data_s;
    logic [MAX_W:0]   ma_s;
    logic             out_valid_q, out_valid_d;
    beat_t            out_q, out_d;
    logic             err_q, err_d;

    assign bus.in_ready = !clear_i && (!out_valid_q || bus.out_ready);
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign legal_s      = (int'(bus.in_chan) < NUM_CH) && (int'(bus.in_data) < MODULUS);
    assign ma_s         = modulo_add(MAX_W'(rd_data_s), MAX_W'(bus.in_data), MOD_L);

    mod_accum_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .CH_W(CH_W)) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear_i),
        .chan_i    (bus.in_chan),
        .rd_data_o (rd_data_s),
        .wr_en_i   (accept_s && legal_s),
        .wr_data_i (WIDTH'(ma_s[MAX_W-1:0]))
    );

    // Output register load/drain and sticky error next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        err_d       = err_q | (accept_s & ~legal_s);
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_d.chan  = MAX_CH_W'(bus.in_chan);
            out_d.data  = legal_s ? ma_s[MAX_W-1:0] : MAX_W'(rd_data_s);
            out_d.wrap  = legal_s & ma_s[MAX_W];
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output beat and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_chan  = CH_W'(out_q.chan);
    assign bus.out_data  = WIDTH'(out_q.data);
    assign bus.out_wrap  = out_q.wrap;
    assign err_o         = err_q;
endmodule
